// File: rtl/mul_arb_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter.
// State encoding, round-robin pick function, default sizes.
package mul_arb_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int WIDTH_DEF = 8;
  localparam int MAX_REQ   = 8;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    RESP
  } state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First set bit of valid at or above ptr, wrapping modulo n.
  // Scanning from the far end lets the nearest hit win last.
  function automatic pick_t rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input logic [2:0]         ptr,
    input int                 n = N_REQ_DEF
  );
    pick_t p;
    int    j;
    p = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      if (k < n) begin
        j = (int'(ptr) + k) % n;
        if (valid[j]) begin
          p.found = 1'b1;
          p.idx   = 3'(j);
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/if_multiplier.sv
// Operand/result bundle for the shared combinational multiplier.
// in1/in2 operands; {overflow, out} is the full-width product.
interface if_multiplier #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0]   in1;
  logic [WIDTH-1:0]   in2;
  logic [2*WIDTH-2:0] out;
  logic               overflow;

  modport mul (
    input  in1,
    input  in2,
    output out,
    output overflow
  );

  modport user (
    output in1,
    output in2,
    input  out,
    input  overflow
  );
endinterface

// File: rtl/dadda_8.sv
// Combinational unsigned Dadda multiplier behind if_multiplier.
// Ports: m (mul modport) -- in1, in2 in; out, overflow out.
module dadda_8 #(
  parameter int WIDTH = 8
) (
  if_multiplier.mul m
);

  localparam int C = 2 * WIDTH;

  logic [WIDTH-1:0] col  [C];
  logic [WIDTH-1:0] ncol [C];
  int               h    [C];
  int               nh   [C];
  logic [C-1:0]     ra;
  logic [C-1:0]     rb;
  logic [C-1:0]     sum;
  logic             x, y, z;
  int               idx, tot, d;

  // Dadda height sequence, largest first.
  function automatic int stage_d(input int s);
    case (s)
      0:       return 13;
      1:       return 9;
      2:       return 6;
      3:       return 4;
      4:       return 3;
      default: return 2;
    endcase
  endfunction

  always_comb begin
    x = 1'b0;
    y = 1'b0;
    z = 1'b0;
    idx = 0;
    tot = 0;
    d = 0;
    for (int c = 0; c < C; c++) begin
      col[c]  = '0;
      ncol[c] = '0;
      h[c]    = 0;
      nh[c]   = 0;
    end
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        col[i+j][h[i+j]] = m.in1[i] & m.in2[j];
        h[i+j] = h[i+j] + 1;
      end
    end
    for (int s = 0; s < 6; s++) begin
      d = stage_d(s);
      if (d < WIDTH) begin
        for (int c = 0; c < C; c++) begin
          ncol[c] = '0;
          nh[c]   = 0;
        end
        for (int c = 0; c < C; c++) begin
          idx = 0;
          // carries already placed in nh[c] count toward height
          tot = h[c] + nh[c];
          for (int k = 0; k < WIDTH; k++) begin
            if (tot > d && h[c] - idx >= 2) begin
              x = col[c][idx];
              y = col[c][idx+1];
              if (tot - d >= 2 && h[c] - idx >= 3) begin
                z = col[c][idx+2];
                idx = idx + 3;
                tot = tot - 2;
              end else begin
                z = 1'b0;
                idx = idx + 2;
                tot = tot - 1;
              end
              ncol[c][nh[c]] = x ^ y ^ z;
              nh[c] = nh[c] + 1;
              if (c + 1 < C) begin
                ncol[c+1][nh[c+1]] = (x & y) | (x & z) | (y & z);
                nh[c+1] = nh[c+1] + 1;
              end
            end
          end
          for (int k = 0; k < WIDTH; k++) begin
            if (k >= idx && k < h[c]) begin
              ncol[c][nh[c]] = col[c][k];
              nh[c] = nh[c] + 1;
            end
          end
        end
        for (int c = 0; c < C; c++) begin
          col[c] = ncol[c];
          h[c]   = nh[c];
        end
      end
    end
    for (int c = 0; c < C; c++) begin
      ra[c] = col[c][0];
      rb[c] = col[c][1];
    end
    sum = ra + rb;
  end

  assign m.out      = sum[C-2:0];
  assign m.overflow = sum[C-1];

endmodule

// File: rtl/rr_arbiter_n.sv
// Combinational round-robin pick over N_REQ request lines.
// Ports: valid, ptr in; grant (one-hot), idx, found out.
module rr_arbiter_n
  import mul_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  ptr,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx,
  output logic             found
);

  logic [MAX_REQ-1:0] v_ext;
  logic [2:0]         p_ext;
  pick_t              p;

  always_comb begin
    v_ext = '0;
    v_ext[N_REQ-1:0] = valid;
    p_ext = '0;
    p_ext[ID_W-1:0] = ptr;
    p = rr_pick(v_ext, p_ext, N_REQ);
    found = p.found;
    idx = ID_W'(p.idx);
    grant = '0;
    if (p.found) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one Dadda multiplier among N_REQ requesters.
// Ports: clk, rst; req_valid/ready/in1/in2; rsp_valid/ready/id/prod; busy.
module mul_share_arbiter
  import mul_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_in1,
  input  logic [N_REQ*WIDTH-1:0] req_in2,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [2*WIDTH-1:0]     rsp_prod,
  output logic                   busy
);

  state_e             state, state_nx;
  logic [ID_W-1:0]    rr_ptr;
  logic [WIDTH-1:0]   op_a, op_b;
  logic [ID_W-1:0]    op_id;
  logic [2*WIDTH-1:0] res_q;
  logic [ID_W-1:0]    id_q;

  logic [N_REQ-1:0]   grant;
  logic [ID_W-1:0]    g_idx;
  logic               g_found;
  logic               can_grant;
  logic               fire;

  rr_arbiter_n #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (g_idx),
    .found (g_found)
  );

  if_multiplier #(.WIDTH(WIDTH)) mif ();

  assign mif.in1 = op_a;
  assign mif.in2 = op_b;

  dadda_8 #(.WIDTH(WIDTH)) u_mul (
    .m (mif)
  );

  // A response slot frees up in the same cycle it is accepted.
  always_comb begin
    can_grant = 1'b0;
    state_nx  = state;
    unique case (state)
      IDLE: can_grant = 1'b1;
      RESP: can_grant = rsp_ready;
      default: can_grant = 1'b0;
    endcase
    fire = can_grant && g_found;
    unique case (state)
      IDLE: if (fire) state_nx = MUL;
      MUL:  state_nx = RESP;
      RESP: if (rsp_ready) state_nx = fire ? MUL : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign req_ready = fire ? grant : '0;
  assign rsp_valid = (state == RESP);
  assign rsp_id    = id_q;
  assign rsp_prod  = res_q;
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      op_a   <= '0;
      op_b   <= '0;
      op_id  <= '0;
      res_q  <= '0;
      id_q   <= '0;
    end else begin
      if (fire) begin
        op_a   <= req_in1[g_idx*WIDTH +: WIDTH];
        op_b   <= req_in2[g_idx*WIDTH +: WIDTH];
        op_id  <= g_idx;
        rr_ptr <= (g_idx == ID_W'(N_REQ - 1)) ? '0 : g_idx + 1'b1;
      end
      if (state == MUL) begin
        res_q <= {mif.overflow, mif.out};
        id_q  <= op_id;
      end
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter with directed vectors.
// Stimulus pushes expected responses; a negedge monitor pops them.
module tb_mul_share_arbiter;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_in1;
  logic [N*W-1:0] req_in2;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IW-1:0]  rsp_id;
  logic [2*W-1:0] rsp_prod;
  logic           busy;

  typedef struct {
    int id;
    int prod;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  mul_share_arbiter #(
    .WIDTH (W),
    .N_REQ (N),
    .ID_W  (IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_in1   (req_in1),
    .req_in2   (req_in2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_in1[i*W +: W] = W'(a);
    req_in2[i*W +: W] = W'(b);
  endtask

  task automatic push(input int id, input int prod);
    exp_t e;
    e.id = id;
    e.prod = prod;
    exp_q.push_back(e);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    neg();
    chk("rst_ready", int'(req_ready), 0);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_id", int'(rsp_id), 0);
    chk("rst_rsp_prod", int'(rsp_prod), 0);
    chk("rst_busy", int'(busy), 0);
    pos();
    rst = 1'b0;
  endtask

  // Monitor: a response is consumed when valid and ready meet.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got id %0d prod %0d expected none",
                 rsp_id, rsp_prod);
      end else begin
        e = exp_q.pop_front();
        chk("rsp_id", int'(rsp_id), e.id);
        chk("rsp_prod", int'(rsp_prod), e.prod);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_in1 = '0;
    req_in2 = '0;
    req_valid = '0;
    rsp_ready = 1'b1;
    rst = 1'b1;
    reset_dut();

    // single op, latency t+2
    set_op(0, 13, 11);
    req_valid = 4'b0001;
    neg();
    chk("t1_ready", int'(req_ready), 1);
    push(0, 143);
    pos();
    req_valid = '0;
    neg();
    chk("t1_mul_valid", int'(rsp_valid), 0);
    chk("t1_mul_busy", int'(busy), 1);
    pos();
    neg();
    chk("t1_lat_valid", int'(rsp_valid), 1);
    pos();
    neg();
    chk("t1_idle_busy", int'(busy), 0);

    // round robin with all valid
    reset_dut();
    set_op(0, 2, 10);
    set_op(1, 3, 20);
    set_op(2, 4, 30);
    set_op(3, 5, 40);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      neg();
      chk("rr_grant", int'(req_ready), 1 << (k % 4));
      push(k % 4, (k % 4 + 2) * 10 * (k % 4 + 1));
      pos();
      if (k == 4) req_valid = '0;
      neg();
      chk("rr_mul_ready", int'(req_ready), 0);
      pos();
    end
    neg();
    pos();

    // backpressure: hold response, no grants
    set_op(1, 200, 100);
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    neg();
    chk("bp_grant", int'(req_ready), 2);
    push(1, 20000);
    pos();
    set_op(3, 7, 9);
    req_valid = 4'b1000;
    neg();
    chk("bp_mul_ready", int'(req_ready), 0);
    pos();
    for (int k = 0; k < 5; k++) begin
      neg();
      chk("bp_valid", int'(rsp_valid), 1);
      chk("bp_prod", int'(rsp_prod), 20000);
      chk("bp_ready", int'(req_ready), 0);
      pos();
    end
    rsp_ready = 1'b1;
    neg();
    chk("bp_release_grant", int'(req_ready), 8);
    push(3, 63);
    pos();
    req_valid = '0;
    neg();
    chk("bp_mul_valid", int'(rsp_valid), 0);
    pos();
    neg();
    pos();

    // back-to-back grant from RESP, zero operand
    set_op(0, 0, 77);
    req_valid = 4'b0001;
    neg();
    chk("b2b_first", int'(req_ready), 1);
    push(0, 0);
    pos();
    set_op(2, 255, 255);
    req_valid = 4'b0100;
    neg();
    chk("b2b_mul_ready", int'(req_ready), 0);
    pos();
    neg();
    chk("b2b_grant2", int'(req_ready), 4);
    push(2, 65025);
    pos();
    req_valid = '0;
    neg();
    chk("b2b_busy", int'(busy), 1);
    chk("b2b_mul_valid", int'(rsp_valid), 0);
    pos();
    neg();
    chk("b2b_resp_valid", int'(rsp_valid), 1);
    pos();

    // skip and wrap: pointer sits at 3
    set_op(1, 6, 7);
    req_valid = 4'b0010;
    neg();
    chk("wrap_grant1", int'(req_ready), 2);
    push(1, 42);
    pos();
    set_op(2, 4, 30);
    req_valid = 4'b1111;
    neg();
    pos();
    neg();
    chk("wrap_next2", int'(req_ready), 4);
    push(2, 120);
    pos();
    req_valid = '0;
    neg();
    pos();
    neg();
    pos();

    // reset during MUL drops the operation
    set_op(0, 2, 10);
    req_valid = 4'b0001;
    neg();
    chk("rmid_grant", int'(req_ready), 1);
    pos();
    req_valid = '0;
    neg();
    chk("rmid_busy", int'(busy), 1);
    #1 rst = 1'b1;
    #1;
    chk("rmid_valid", int'(rsp_valid), 0);
    chk("rmid_busy0", int'(busy), 0);
    pos();
    pos();
    neg();
    chk("rmid_hold", int'(rsp_valid), 0);
    pos();
    rst = 1'b0;
    req_valid = 4'b1111;
    neg();
    chk("rmid_first0", int'(req_ready), 1);
    push(0, 20);
    pos();
    req_valid = '0;
    neg();
    pos();
    neg();
    pos();
    neg();

    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
Shares one combinational Dadda multiplier (dadda_8 through if_multiplier) among N_REQ requesters. A round-robin arbiter grants one requester at a time. The block latches the granted operands, registers the multiplier result one cycle later, and returns it with the requester id over a valid/ready response channel. It sits between the approximate-multiplier datapath and the accelerator lanes that consume products.

Parameters:
WIDTH, 8, operand width per input; also the multiplier WIDTH
N_REQ, 4, number of requesters (2..8)
ID_W, 2, requester id width; must equal clog2(N_REQ)

Ports:
clk  in  1  single clock, rising-edge
rst  in  1  asynchronous, active-high reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester grant; one-hot or zero
req_in1  in  N_REQ*WIDTH  packed operand A; requester i uses slice i
req_in2  in  N_REQ*WIDTH  packed operand B; requester i uses slice i
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  ID_W  index of the requester that owns the response
rsp_prod  out  2*WIDTH  product {overflow, out}, zero-extended to 2*WIDTH
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-high.
- Reset values:
  - state=IDLE, rr_ptr=0.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_prod=0, busy=0.
  - Operand and result registers are 0.
- FSM states: IDLE, MUL, RESP.
- IDLE:
  - can_grant=1.
  - If any req_valid is set, grant the first set bit scanning from rr_ptr upward, with modulo N_REQ wrap.
  - req_ready[g] is asserted combinationally in the same cycle.
  - On the handshake, latch in1/in2/id into the operand regs, set rr_ptr=(g+1)%N_REQ, and go to MUL.
- MUL:
  - The operand regs drive the multiplier.
  - On the clock edge, capture {overflow, out} zero-extended into the result reg, copy id into rsp_id, and go to RESP.
  - No grant is issued in MUL.
- RESP:
  - rsp_valid=1.
  - rsp_prod and rsp_id stay stable until the handshake.
  - If rsp_ready=0: hold RESP with no grant.
  - If rsp_ready=1: can_grant=1. If a grant occurs in the same cycle, latch the new operands and go to MUL; otherwise go to IDLE.
- Latency and throughput:
  - Request handshake in cycle t gives rsp_valid in cycle t+2.
  - Sustained throughput with rsp_ready held at 1 is one product per 2 cycles.
- req_ready rules:
  - req_ready is asserted only when can_grant=1, and only for a requester whose req_valid is set.
  - It never depends on req_in*.
  - The block never drops a request that was not granted; requesters hold req_valid and operands until they see req_ready.
- Fairness:
  - With all N_REQ valid continuously, grants rotate 0,1,…,N_REQ-1,0.
  - No requester waits more than N_REQ-1 grants.
- Arithmetic:
  - Operands are unsigned WIDTH bits.
  - rsp_prod is the multiplier output as delivered; the block does not correct approximation errors.
- Boundary conditions:
  - Zero operands return 0.
  - rr_ptr wraps from N_REQ-1 to 0.
  - A requester that deasserts req_valid before its grant is simply skipped.
- Reset mid-operation:
  - Asserting rst in MUL or RESP drops the in-flight operation; no response is ever produced for it.
  - After release: IDLE, rr_ptr=0.

Decomposition:
- Package mul_arb_pkg holds:
  - the state enum typedef (IDLE, MUL, RESP);
  - the function rr_pick(valid, ptr), which returns the grant index and a found flag;
  - the default constants for N_REQ and WIDTH.
- One natural sub-module, rr_arbiter_n: combinational round-robin pick from req_valid and rr_ptr, producing a one-hot grant and an index.
- The multiplier is instantiated as dadda_8 through an if_multiplier instance.

Test Plan:
- Single op: after reset, req_valid=4'b0001, in1=13, in2=11 → req_ready[0] high the same cycle; rsp_valid at t+2 with rsp_prod=143, rsp_id=0.
- Round robin: all four valid continuously, rsp_ready=1 → grants 0,1,2,3,0 on cycles t, t+2, t+4, t+6, t+8; rsp_id follows the same order.
- Backpressure: rsp_ready=0 for 5 cycles during RESP with in1=200, in2=100 → rsp_valid held, rsp_prod=20000 stable, no req_ready pulses; after rsp_ready=1, the next grant occurs that cycle.
- Back-to-back grant: RESP with rsp_ready=1 and req_valid[2]=1 → grant 2 in the same cycle, state goes to MUL, no idle bubble.
- Reset mid-op: assert rst during MUL → rsp_valid stays 0; after release, busy=0 and the first grant goes to requester 0.
- Skip and wrap: rr_ptr=3, req_valid=4'b0010 → grant 1; rr_ptr becomes 2.
